hwag_crank_gen: RTL and testbench

//  Synthesisable crank/cam trigger-wheel pattern generator: the transmitter side of the hwag VR/cam inputs.

---
 rtl/hwag_crank_gen.sv | 160 ++++++++++++++++
 tb/tb_hwag_crank_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hwag_crank_gen.sv
// Crank/cam trigger-wheel generator: toothed VR wave with long gap tooth plus 720-deg cam.
// Define HWAG_GEN_CAM_EN to build the cam phase/edge logic; otherwise cam_out=1, cam_phase=0.
module hwag_crank_gen #(
   parameter int PRESC_W = 8,
   parameter int TOOTH_W = 16,
   parameter int TEETH_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc_top,
   input  logic [TOOTH_W-1:0] tooth_top,
   input  logic [TEETH_W-1:0] teeth_top,
   input  logic [1:0]         gap_mult,
   input  logic [TEETH_W-1:0] cam_tog_tooth,
   input  logic [TEETH_W-1:0] cam_fall_tooth,
   input  logic [TEETH_W-1:0] cam_rise_tooth,
   output logic               vr_out,
   output logic               cam_out,
   output logic               cam_phase,
   output logic [TEETH_W-1:0] tooth_idx,
   output logic               rev_stb
);

   localparam int CT_W = TOOTH_W + 2;

   logic [PRESC_W-1:0] r_scnt;
   logic [CT_W-1:0]    r_tckc;
   logic [CT_W-1:0]    r_cur_top;
   logic [PRESC_W-1:0] r_sh_presc;
   logic [TOOTH_W-1:0] r_sh_tooth;
   logic [TEETH_W-1:0] r_sh_teeth;
   logic [1:0]         r_sh_gap;
   logic               r_vr;
   logic [TEETH_W-1:0] r_idx;
   logic               r_stb;

   logic               w_tick;
   logic               w_tend;
   logic               w_adv;
   logic               w_wrap;
   logic               w_pre_gap;
   logic [1:0]         w_gm;
   logic [CT_W-1:0]    w_base;
   logic [CT_W-1:0]    w_gap_top;
   logic [CT_W-1:0]    w_half;

   assign w_tick    = (r_scnt == r_sh_presc);
   assign w_tend    = (r_tckc == r_cur_top);
   assign w_adv     = w_tick & w_tend;
   assign w_wrap    = (r_idx == r_sh_teeth);
   assign w_pre_gap = (r_idx == r_sh_teeth - TEETH_W'(1));
   assign w_gm      = (r_sh_gap == 2'd0) ? 2'd1 : r_sh_gap;
   assign w_base    = {2'b00, r_sh_tooth} + CT_W'(1);
   assign w_gap_top = w_base * {{(CT_W-2){1'b0}}, w_gm} - CT_W'(1);
   assign w_half    = r_cur_top >> 1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scnt     <= '0;
         r_tckc     <= '0;
         r_cur_top  <= '0;
         r_sh_presc <= '0;
         r_sh_tooth <= '0;
         r_sh_teeth <= '0;
         r_sh_gap   <= '0;
         r_vr       <= 1'b0;
         r_idx      <= '0;
         r_stb      <= 1'b0;
      end else if (!en) begin
         r_scnt     <= '0;
         r_tckc     <= '0;
         r_cur_top  <= {2'b00, tooth_top};
         r_sh_presc <= presc_top;
         r_sh_tooth <= tooth_top;
         r_sh_teeth <= teeth_top;
         r_sh_gap   <= gap_mult;
         r_vr       <= 1'b0;
         r_idx      <= '0;
         r_stb      <= 1'b0;
      end else begin
         r_stb <= 1'b0;
         if (w_tick) begin
            r_scnt <= '0;
            if (w_tend) begin
               r_tckc <= '0;
               r_vr   <= 1'b0;
               if (w_wrap) begin
                  // New revolution picks up the live config as its shadow.
                  r_idx      <= '0;
                  r_stb      <= 1'b1;
                  r_cur_top  <= {2'b00, tooth_top};
                  r_sh_presc <= presc_top;
                  r_sh_tooth <= tooth_top;
                  r_sh_teeth <= teeth_top;
                  r_sh_gap   <= gap_mult;
               end else begin
                  r_idx <= r_idx + TEETH_W'(1);
                  if (w_pre_gap) r_cur_top <= w_gap_top;
               end
            end else begin
               if (r_tckc == w_half) r_vr <= 1'b1;
               r_tckc <= r_tckc + CT_W'(1);
            end
         end else begin
            r_scnt <= r_scnt + PRESC_W'(1);
         end
      end
   end

`ifdef HWAG_GEN_CAM_EN
   logic               r_cam;
   logic               r_ph;
   logic [TEETH_W-1:0] r_sh_tog;
   logic [TEETH_W-1:0] r_sh_fall;
   logic [TEETH_W-1:0] r_sh_rise;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cam     <= 1'b1;
         r_ph      <= 1'b0;
         r_sh_tog  <= '0;
         r_sh_fall <= '0;
         r_sh_rise <= '0;
      end else if (!en) begin
         r_cam     <= 1'b1;
         r_ph      <= 1'b0;
         r_sh_tog  <= cam_tog_tooth;
         r_sh_fall <= cam_fall_tooth;
         r_sh_rise <= cam_rise_tooth;
      end else if (w_adv) begin
         if (w_wrap) begin
            r_sh_tog  <= cam_tog_tooth;
            r_sh_fall <= cam_fall_tooth;
            r_sh_rise <= cam_rise_tooth;
         end else begin
            if (r_idx == r_sh_tog) r_ph <= ~r_ph;
            // Rise is evaluated last so it wins when both teeth match.
            if (r_ph) begin
               if (r_idx == r_sh_fall) r_cam <= 1'b0;
               if (r_idx == r_sh_rise) r_cam <= 1'b1;
            end
         end
      end
   end

   assign cam_out   = r_cam;
   assign cam_phase = r_ph;
`else
   logic w_cam_unused;
   assign w_cam_unused = ^{cam_tog_tooth, cam_fall_tooth, cam_rise_tooth};
   assign cam_out      = 1'b1;
   assign cam_phase    = 1'b0;
`endif

   assign vr_out    = r_vr;
   assign tooth_idx = r_idx;
   assign rev_stb   = r_stb;

endmodule

// File: tb/tb_hwag_crank_gen.sv
// Directed bench for hwag_crank_gen: timing table per wheel config, then
// reset/enable aborts, shadowed config change and the cam pattern.
module tb_hwag_crank_gen;

   logic        clk;
   logic        rst;
   logic        en;
   logic [7:0]  presc_top;
   logic [15:0] tooth_top;
   logic [7:0]  teeth_top;
   logic [1:0]  gap_mult;
   logic [7:0]  cam_tog_tooth;
   logic [7:0]  cam_fall_tooth;
   logic [7:0]  cam_rise_tooth;
   logic        vr_out;
   logic        cam_out;
   logic        cam_phase;
   logic [7:0]  tooth_idx;
   logic        rev_stb;

   hwag_crank_gen dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .presc_top      (presc_top),
      .tooth_top      (tooth_top),
      .teeth_top      (teeth_top),
      .gap_mult       (gap_mult),
      .cam_tog_tooth  (cam_tog_tooth),
      .cam_fall_tooth (cam_fall_tooth),
      .cam_rise_tooth (cam_rise_tooth),
      .vr_out         (vr_out),
      .cam_out        (cam_out),
      .cam_phase      (cam_phase),
      .tooth_idx      (tooth_idx),
      .rev_stb        (rev_stb)
   );

   typedef struct {
      int presc;
      int tt;
      int teeth;
      int gm;
      int e_norm;
      int e_rise;
      int e_gap;
      int e_grise;
      int e_rev;
   } vec_t;

   vec_t vecs[5];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_cfg(input int p, input int t, input int n, input int g);
      presc_top = 8'(p);
      tooth_top = 16'(t);
      teeth_top = 8'(n);
      gap_mult  = 2'(g);
   endtask

   task automatic go_idle();
      en = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle(input string nm);
      check({nm, "_vr"}, int'(vr_out), 0);
      check({nm, "_cam"}, int'(cam_out), 1);
      check({nm, "_ph"}, int'(cam_phase), 0);
      check({nm, "_idx"}, int'(tooth_idx), 0);
      check({nm, "_stb"}, int'(rev_stb), 0);
   endtask

   task automatic wait_idx(input int k, input int bound);
      int n = 0;
      while (int'(tooth_idx) != k && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (int'(tooth_idx) != k) check("timeout_idx", int'(tooth_idx), k);
   endtask

   // Waits for a rev_stb, then times the following revolution.
   task automatic run_rev(input int gap_i, output int rl, output int nl,
                          output int nr, output int gl, output int gr);
      int n = 0;
      int t0, ts1, ts2, r1, tg, rg;
      logic pv;
      int   pi;
      rl = -1; nl = -1; nr = -1; gl = -1; gr = -1;
      while (!rev_stb && n < 40000) begin
         @(negedge clk);
         n++;
      end
      if (!rev_stb) begin
         check("timeout_stb", 0, 1);
         return;
      end
      t0 = cyc; ts1 = -1; ts2 = -1; r1 = -1; tg = -1; rg = -1;
      pv = vr_out;
      pi = int'(tooth_idx);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (rev_stb) break;
         if (int'(tooth_idx) != pi) begin
            if (tooth_idx == 8'd1) ts1 = cyc;
            if (tooth_idx == 8'd2) ts2 = cyc;
            if (int'(tooth_idx) == gap_i) tg = cyc;
         end
         if (vr_out && !pv) begin
            if (tooth_idx == 8'd1 && r1 < 0) r1 = cyc;
            if (int'(tooth_idx) == gap_i && rg < 0) rg = cyc;
         end
         pv = vr_out;
         pi = int'(tooth_idx);
      end while (n < 40000);
      if (!rev_stb) begin
         check("timeout_rev", 0, 1);
         return;
      end
      rl = cyc - t0;
      nl = ts2 - ts1;
      nr = r1 - ts1;
      gl = cyc - tg;
      gr = rg - tg;
   endtask

   initial begin
      int rl, nl, nr, gl, gr, n, ta;
      logic [19:0] e_ph;
      logic [19:0] e_cam;

      vecs[0] = '{3, 63, 57, 3, 256, 128, 768, 384, 15360};
      vecs[1] = '{3, 63, 57, 0, 256, 128, 256, 128, 14848};
      vecs[2] = '{0, 7, 9, 2, 8, 4, 16, 8, 88};
      vecs[3] = '{1, 4, 3, 1, 10, 6, 10, 6, 40};
      vecs[4] = '{0, 5, 4, 3, 6, 3, 18, 9, 42};

      rst = 1'b0;
      en  = 1'b0;
      set_cfg(0, 7, 9, 2);
      cam_tog_tooth  = 8'd0;
      cam_fall_tooth = 8'd0;
      cam_rise_tooth = 8'd0;
      @(negedge clk);
      check_idle("rst");
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         set_cfg(vecs[i].presc, vecs[i].tt, vecs[i].teeth, vecs[i].gm);
         go_idle();
         check_idle($sformatf("v%0d_idle", i));
         en = 1'b1;
         run_rev(vecs[i].teeth, rl, nl, nr, gl, gr);
         check($sformatf("v%0d_rev", i), rl, vecs[i].e_rev);
         check($sformatf("v%0d_tooth", i), nl, vecs[i].e_norm);
         check($sformatf("v%0d_rise", i), nr, vecs[i].e_rise);
         check($sformatf("v%0d_gap", i), gl, vecs[i].e_gap);
         check($sformatf("v%0d_grise", i), gr, vecs[i].e_grise);
      end

      // Config change mid-revolution only lands after the wrap.
      set_cfg(0, 7, 19, 1);
      go_idle();
      en = 1'b1;
      run_rev(19, rl, nl, nr, gl, gr);
      wait_idx(10, 200);
      tooth_top = 16'd3;
      wait_idx(11, 200);
      ta = cyc;
      wait_idx(12, 200);
      check("chg_old_tooth", cyc - ta, 8);
      run_rev(19, rl, nl, nr, gl, gr);
      check("chg_new_tooth", nl, 4);
      check("chg_new_rev", rl, 80);

      // Async reset in the middle of the high half of the gap tooth.
      set_cfg(0, 7, 9, 2);
      go_idle();
      en = 1'b1;
      wait_idx(9, 200);
      n = 0;
      while (!vr_out && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("gap_vr_high", int'(vr_out), 1);
      #1 rst = 1'b0;
      #1;
      check_idle("async");
      @(negedge clk);
      rst = 1'b1;
      run_rev(9, rl, nl, nr, gl, gr);
      check("post_rst_rev", rl, 88);

      // Dropping en mid-tooth returns to idle on the next clock.
      wait_idx(5, 200);
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check_idle("en_drop");
      en = 1'b1;
      run_rev(9, rl, nl, nr, gl, gr);
      check("en_restart_rev", rl, 88);

      // Cam pattern over two revolutions, one tooth = 2 clk.
      set_cfg(0, 1, 9, 1);
      cam_tog_tooth  = 8'd3;
      cam_fall_tooth = 8'd7;
      cam_rise_tooth = 8'd1;
`ifdef HWAG_GEN_CAM_EN
      e_ph  = 20'b0000_0011_1111_1111_0000;
      e_cam = 20'b1111_1111_0000_1111_1111;
`else
      e_ph  = 20'b0000_0000_0000_0000_0000;
      e_cam = 20'b1111_1111_1111_1111_1111;
`endif
      go_idle();
      en = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         wait_idx(k % 10, 20);
         check($sformatf("cam_ph_t%0d", k), int'(cam_phase), int'(e_ph[k]));
         check($sformatf("cam_out_t%0d", k), int'(cam_out), int'(e_cam[k]));
      end

      en = 1'b0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
